// File: rtl/lenet_pool1_if.sv
// Valid/ready pixel stream used on both sides of the LeNet S2 pooling stage.
// The producer drives valid/data and the consumer drives ready.
interface lenet_pool1_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         valid;
  logic                         ready;
  logic signed [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/lenet_pool1.sv
// Streaming 2x2 / stride-2 pooling stage (LeNet S2).
// Raster-order pixels come in; pooled pixels go out, also in raster order.
// Each horizontal pair is combined as soon as its odd column arrives. The
// pair result from an even row is parked in a half-width line buffer and
// merged with the matching pair from the odd row below it, so only one row
// of partial results is ever stored.
module lenet_pool1 #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_WIDTH   = 28,
  parameter int POOL_MODE  = 0    // 0 = max, 1 = average (floor)
) (
  input  logic           clk,
  input  logic           rst,
  lenet_pool1_if.slave   in_if,
  lenet_pool1_if.master  out_if,
  output logic           out_last,
  output logic           frame_done
);

  localparam int CW    = $clog2(IN_WIDTH);
  localparam int HALF  = IN_WIDTH / 2;
  localparam int HW    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int SUM_W = DATA_WIDTH + 2;  // holds the sum of four pixels
  localparam logic [CW-1:0] LAST_IDX = CW'(IN_WIDTH - 1);

  logic [CW-1:0]                col;
  logic [CW-1:0]                row;
  logic [HW-1:0]                col_half;
  logic signed [DATA_WIDTH-1:0] pair_reg;
  logic signed [SUM_W-1:0]      line_buf [HALF];

  logic                         out_valid_q;
  logic signed [DATA_WIDTH-1:0] out_data_q;

  logic                         in_ready;
  logic                         accept;
  logic                         out_xfer;
  logic                         load;
  logic                         buf_wr;
  logic signed [SUM_W-1:0]      lb_rd;
  logic signed [SUM_W-1:0]      pair_v;
  logic signed [SUM_W-1:0]      quad_v;
  logic signed [DATA_WIDTH-1:0] pooled;

  // A new beat may enter whenever the output register is empty or draining.
  assign in_ready     = !out_valid_q || out_if.ready;
  assign in_if.ready  = in_ready;
  assign accept       = in_if.valid && in_ready;
  assign out_xfer     = out_valid_q && out_if.ready;
  assign load         = accept && col[0] && row[0];
  assign buf_wr       = accept && col[0] && !row[0];
  assign col_half     = HW'(col >> 1);

  assign out_if.valid = out_valid_q;
  assign out_if.data  = out_data_q;

  // Combine the horizontal pair, then the pair with the stored row above.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    lb_rd  = line_buf[col_half];
    pair_v = '0;
    quad_v = '0;
    pooled = '0;
    if (POOL_MODE == 1) begin
      pair_v = SUM_W'(pair_reg) + SUM_W'(in_if.data);
      quad_v = lb_rd + pair_v;
      pooled = DATA_WIDTH'(quad_v >>> 2);
    end else begin
      pair_v = (in_if.data > pair_reg) ? SUM_W'(in_if.data) : SUM_W'(pair_reg);
      quad_v = (pair_v > lb_rd) ? pair_v : lb_rd;
      pooled = DATA_WIDTH'(quad_v);
    end
  end

  // Position counters, even-column pair latch and the output register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      col         <= '0;
      row         <= '0;
      pair_reg    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= out_xfer && out_last;

      if (accept) begin
        if (!col[0]) begin
          pair_reg <= in_if.data;
        end
        if (col == LAST_IDX) begin
          col <= '0;
          row <= (row == LAST_IDX) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      // A load in the same cycle as a transfer simply replaces the value.
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= pooled;
        out_last    <= (row == LAST_IDX) && (col == LAST_IDX);
      end else if (out_xfer) begin
        out_valid_q <= 1'b0;
        out_last    <= 1'b0;
      end
    end
  end

  // Even-row pair results wait here for the odd row below them.
  // NOTE: the line buffer is deliberately not reset; an even row always
  // overwrites each entry before the odd row reads it.
  always_ff @(posedge clk) begin
    if (buf_wr) begin
      line_buf[col_half] <= pair_v;
    end
  end

endmodule

// File: tb/tb_lenet_pool1.sv
// Directed bench for lenet_pool1: four instances cover the 4x4 max/average
// and 2x2 max/average configurations, all with 16-bit pixels.
module tb_lenet_pool1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               in_valid  [4];
  logic signed [15:0] in_data   [4];
  logic               out_ready [4];
  logic               rdy       [4];
  logic               ov        [4];
  logic signed [15:0] od        [4];
  logic               ol        [4];
  logic               fd        [4];

  // Instance g: IN_WIDTH = 4 for g < 2 else 2; POOL_MODE = g % 2.
  for (genvar g = 0; g < 4; g++) begin : gen_dut
    lenet_pool1_if #(.DATA_WIDTH(16)) sif ();
    lenet_pool1_if #(.DATA_WIDTH(16)) mif ();

    assign sif.valid = in_valid[g];
    assign sif.data  = in_data[g];
    assign rdy[g]    = sif.ready;
    assign mif.ready = out_ready[g];
    assign ov[g]     = mif.valid;
    assign od[g]     = mif.data;

    lenet_pool1 #(
      .DATA_WIDTH(16),
      .IN_WIDTH  ((g < 2) ? 4 : 2),
      .POOL_MODE (g % 2)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_if     (sif),
      .out_if    (mif),
      .out_last  (ol[g]),
      .frame_done(fd[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor: records every transferred pixel, out_last transfers and
  // frame_done pulses that do not follow an out_last transfer.
  logic signed [15:0] outs [4][64];
  int   n_out   [4] = '{default: 0};
  int   n_last  [4] = '{default: 0};
  int   n_fd    [4] = '{default: 0};
  int   n_fdbad [4] = '{default: 0};
  logic prev_lx [4] = '{default: 1'b0};

  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (fd[g] === 1'b1) begin
        n_fd[g]++;
        if (!prev_lx[g]) n_fdbad[g]++;
      end
      prev_lx[g] = (ov[g] === 1'b1) && out_ready[g] && (ol[g] === 1'b1);
      if (ov[g] === 1'b1 && out_ready[g]) begin
        if (n_out[g] < 64) outs[g][n_out[g]] = od[g];
        n_out[g]++;
        if (ol[g] === 1'b1) n_last[g]++;
      end
    end
  end

  // Present one pixel and return just after the edge that accepts it.
  // valid stays high so consecutive calls stream without gaps.
  task automatic send(input int g, input logic signed [15:0] px);
    int t = 0;
    in_valid[g] = 1'b1;
    in_data[g]  = px;
    @(negedge clk);
    while (!rdy[g] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("send_timeout", t, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int g, input int cycles);
    in_valid[g] = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic expect_outs(input string tag, input int g, input int start,
                             input int n, input int exp_v[8]);
    check({tag, "_count"}, n_out[g] - start, n);
    for (int k = 0; k < n; k++) begin
      if (start + k < 64)
        check($sformatf("%s_o%0d", tag, k), outs[g][start + k], exp_v[k]);
    end
  endtask

  int s_out, s_last, s_fd, stall_hi;
  int exp_v [8];

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 4; g++) begin
      in_valid[g]  = 1'b0;
      in_data[g]   = '0;
      out_ready[g] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    check("rst_out_valid", ov[0], 0);
    check("rst_out_data", od[0], 0);
    check("rst_out_last", ol[0], 0);
    check("rst_frame_done", fd[0], 0);
    check("rst_in_ready", rdy[0], 1);

    // 4x4 max, ramp 0..15, with output latency checks.
    s_out = n_out[0]; s_last = n_last[0]; s_fd = n_fd[0];
    for (int p = 0; p < 16; p++) begin
      send(0, 16'(p));
      if (p == 4) check("max_lat_before", ov[0], 0);
      if (p == 5) begin
        check("max_lat_valid", ov[0], 1);
        check("max_lat_data", od[0], 5);
      end
      if (p == 15) begin
        check("max_last_data", od[0], 15);
        check("max_last_flag", ol[0], 1);
      end
    end
    idle(0, 5);
    exp_v = '{5, 7, 13, 15, 0, 0, 0, 0};
    expect_outs("max4", 0, s_out, 4, exp_v);
    check("max4_last_cnt", n_last[0] - s_last, 1);
    check("max4_fd_cnt", n_fd[0] - s_fd, 1);

    // 4x4 average, same ramp.
    s_out = n_out[1];
    for (int p = 0; p < 16; p++) send(1, 16'(p));
    idle(1, 5);
    exp_v = '{2, 4, 10, 12, 0, 0, 0, 0};
    expect_outs("avg4", 1, s_out, 4, exp_v);

    // 2x2 signed: max, floor average, and no overflow at full scale.
    s_out = n_out[2];
    for (int p = 1; p <= 4; p++) send(2, 16'(-p));
    idle(2, 4);
    exp_v = '{-1, 0, 0, 0, 0, 0, 0, 0};
    expect_outs("max2_neg", 2, s_out, 1, exp_v);

    s_out = n_out[3];
    for (int p = 1; p <= 4; p++) send(3, 16'(-p));
    idle(3, 4);
    exp_v = '{-3, 0, 0, 0, 0, 0, 0, 0};
    expect_outs("avg2_neg", 3, s_out, 1, exp_v);

    s_out = n_out[3];
    for (int p = 0; p < 4; p++) send(3, 16'sd32767);
    idle(3, 4);
    exp_v = '{32767, 0, 0, 0, 0, 0, 0, 0};
    expect_outs("avg2_full", 3, s_out, 1, exp_v);

    // Backpressure: hold out_ready low for 10 cycles after the first output.
    s_out = n_out[0];
    for (int p = 0; p < 6; p++) send(0, 16'(p));
    out_ready[0] = 1'b0;
    in_data[0]   = 16'sd6;
    @(negedge clk);
    check("bp_in_ready_low", rdy[0], 0);
    check("bp_valid_held", ov[0], 1);
    stall_hi = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rdy[0]) stall_hi++;
    end
    check("bp_ready_stayed_low", stall_hi, 0);
    check("bp_data_held", od[0], 5);
    @(posedge clk);
    #1 out_ready[0] = 1'b1;
    for (int p = 6; p < 16; p++) send(0, 16'(p));
    idle(0, 5);
    exp_v = '{5, 7, 13, 15, 0, 0, 0, 0};
    expect_outs("bp", 0, s_out, 4, exp_v);

    // Two frames back to back without a gap.
    s_out = n_out[0]; s_last = n_last[0]; s_fd = n_fd[0];
    for (int p = 0; p < 16; p++) send(0, 16'(p));
    for (int p = 0; p < 16; p++) send(0, 16'(100 + p));
    idle(0, 5);
    exp_v = '{5, 7, 13, 15, 105, 107, 113, 115};
    expect_outs("b2b", 0, s_out, 8, exp_v);
    check("b2b_last_cnt", n_last[0] - s_last, 2);
    check("b2b_fd_cnt", n_fd[0] - s_fd, 2);

    // Reset mid-frame after 6 pixels, then a clean frame.
    for (int p = 0; p < 6; p++) send(0, 16'(p));
    in_valid[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_out_valid", ov[0], 0);
    s_out = n_out[0];
    for (int p = 0; p < 16; p++) send(0, 16'(p));
    idle(0, 5);
    exp_v = '{5, 7, 13, 15, 0, 0, 0, 0};
    expect_outs("after_rst", 0, s_out, 4, exp_v);

    for (int g = 0; g < 4; g++)
      check($sformatf("fd_without_last_g%0d", g), n_fdbad[g], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
